// File: rtl/output_accumulation_buffer_pkg.sv
// Output accumulation buffer: shared state enum and helpers.
// Address composition is shared so producers agree on the map layout.
package output_accumulation_buffer_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    FLUSH,
    DRAIN
  } oab_state_e;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned oab_addr(
    input int unsigned ch,
    input int unsigned h,
    input int unsigned w,
    input int unsigned oh,
    input int unsigned ow
  );
    return (ch * oh + h) * ow + w;
  endfunction

endpackage

// File: rtl/output_accumulation_buffer_acc_rmw_pipe.sv
// Two-stage read-modify-write accumulator around the map storage.
// Ports: acc_* accumulate request, zero_* clear write, ext_raddr drain read, rdata, busy.
module acc_rmw_pipe #(
  parameter int VAL_W = 32,
  parameter int ACC_W = 32,
  parameter int DEPTH = 64,
  parameter int A_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             acc_en,
  input  logic [A_W-1:0]   acc_addr,
  input  logic [VAL_W-1:0] acc_val,
  input  logic             zero_en,
  input  logic [A_W-1:0]   zero_addr,
  input  logic [A_W-1:0]   ext_raddr,
  output logic [ACC_W-1:0] rdata,
  output logic             busy
);

  logic             s1_v;
  logic             s2_v;
  logic [A_W-1:0]   s1_addr;
  logic [A_W-1:0]   s2_addr;
  logic [VAL_W-1:0] s1_val;
  logic [VAL_W-1:0] s2_val;
  logic             fwd_q;
  logic [ACC_W-1:0] fwd_sum;
  logic [ACC_W-1:0] mem_q;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] mem [DEPTH];
  logic [A_W-1:0]   raddr;
  logic [A_W-1:0]   waddr;
  logic [ACC_W-1:0] wdata;
  logic             we;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      fwd_q <= 1'b0;
    end else begin
      s1_v  <= acc_en;
      s2_v  <= s1_v;
      // S2 writes this cycle, so S1's read would see stale data
      fwd_q <= s1_v && s2_v && (s2_addr == s1_addr);
    end
  end

  always_ff @(posedge clock) begin
    s1_addr <= acc_addr;
    s1_val  <= acc_val;
    s2_addr <= s1_addr;
    s2_val  <= s1_val;
    fwd_sum <= sum;
  end

  always_comb begin
    base  = fwd_q ? fwd_sum : mem_q;
    sum   = base + ACC_W'($signed(s2_val));
    raddr = s1_v ? s1_addr : ext_raddr;
    we    = s2_v | zero_en;
    waddr = s2_v ? s2_addr : zero_addr;
    wdata = s2_v ? sum : '0;
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    mem_q <= mem[raddr];
  end

  assign rdata = mem_q;
  assign busy  = s1_v | s2_v;

endmodule

// File: rtl/output_accumulation_buffer.sv
// Accumulates PE partial sums into an output map and drains it as a stream.
// Ports: in_* PE write side, start_drain, out_* drain stream, drain_done, drop_count.
module output_accumulation_buffer
  import output_accumulation_buffer_pkg::*;
#(
  parameter  int VAL_W = 32,
  parameter  int ACC_W = 32,
  parameter  int OUT_C = 4,
  parameter  int OUT_H = 4,
  parameter  int OUT_W = 4,
  localparam int C_LOG = idx_w(OUT_C),
  localparam int H_LOG = idx_w(OUT_H),
  localparam int W_LOG = idx_w(OUT_W),
  localparam int DEPTH = OUT_C * OUT_H * OUT_W,
  localparam int A_W   = idx_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_en,
  input  logic [C_LOG-1:0] in_ch,
  input  logic [H_LOG-1:0] in_h,
  input  logic [W_LOG-1:0] in_w,
  input  logic [VAL_W-1:0] in_val,
  output logic             in_ready,
  input  logic             start_drain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [C_LOG-1:0] out_ch,
  output logic [H_LOG-1:0] out_h,
  output logic [W_LOG-1:0] out_w,
  output logic             drain_done,
  output logic [15:0]      drop_count
);

  oab_state_e       state;
  oab_state_e       state_n;
  logic [A_W-1:0]   clr_ptr;
  logic [A_W-1:0]   p;
  logic [C_LOG-1:0] dc;
  logic [H_LOG-1:0] dh;
  logic [W_LOG-1:0] dw;
  logic [15:0]      drop_q;
  logic             done_q;

  logic [31:0]      ch_x;
  logic [31:0]      h_x;
  logic [31:0]      w_x;
  logic             in_range;
  logic             acc_en;
  logic             drop;
  logic [A_W-1:0]   acc_addr;
  logic             hs;
  logic             last;
  logic             zero_en;
  logic [A_W-1:0]   zero_addr;
  logic [A_W-1:0]   ext_raddr;
  logic [ACC_W-1:0] rdata;
  logic             busy;

  always_comb begin
    ch_x     = 32'(in_ch);
    h_x      = 32'(in_h);
    w_x      = 32'(in_w);
    in_range = (ch_x < OUT_C) && (h_x < OUT_H) && (w_x < OUT_W);
    in_ready = (state == ACCUM);
    acc_en   = in_en && in_ready && in_range;
    drop     = in_en && !acc_en;
    acc_addr = A_W'(oab_addr(ch_x, h_x, w_x, OUT_H, OUT_W));
    hs       = (state == DRAIN) && out_ready;
    last     = (p == A_W'(DEPTH - 1));
  end

  always_comb begin
    state_n   = state;
    zero_en   = 1'b0;
    zero_addr = clr_ptr;
    ext_raddr = p;
    unique case (state)
      CLEAR: begin
        zero_en = 1'b1;
        if (clr_ptr == A_W'(DEPTH - 1)) begin
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (start_drain) begin
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        // prefetch entry 0 so DRAIN presents it on its first cycle
        ext_raddr = '0;
        if (!busy) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          zero_en   = 1'b1;
          zero_addr = p;
          ext_raddr = p + A_W'(1);
          if (last) begin
            state_n = ACCUM;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      p       <= '0;
      dc      <= '0;
      dh      <= '0;
      dw      <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= hs && last;
      if (state == CLEAR && state_n == CLEAR) begin
        clr_ptr <= clr_ptr + A_W'(1);
      end else begin
        clr_ptr <= '0;
      end
      if (drop && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
      if (state == FLUSH) begin
        p  <= '0;
        dc <= '0;
        dh <= '0;
        dw <= '0;
      end else if (hs) begin
        p <= p + A_W'(1);
        if (dw == W_LOG'(OUT_W - 1)) begin
          dw <= '0;
          if (dh == H_LOG'(OUT_H - 1)) begin
            dh <= '0;
            if (dc == C_LOG'(OUT_C - 1)) begin
              dc <= '0;
            end else begin
              dc <= dc + C_LOG'(1);
            end
          end else begin
            dh <= dh + H_LOG'(1);
          end
        end else begin
          dw <= dw + W_LOG'(1);
        end
      end
    end
  end

  acc_rmw_pipe #(
    .VAL_W (VAL_W),
    .ACC_W (ACC_W),
    .DEPTH (DEPTH),
    .A_W   (A_W)
  ) u_rmw (
    .clock     (clock),
    .reset     (reset),
    .acc_en    (acc_en),
    .acc_addr  (acc_addr),
    .acc_val   (in_val),
    .zero_en   (zero_en),
    .zero_addr (zero_addr),
    .ext_raddr (ext_raddr),
    .rdata     (rdata),
    .busy      (busy)
  );

  assign out_valid  = (state == DRAIN);
  assign out_data   = out_valid ? rdata : '0;
  assign out_ch     = out_valid ? dc : '0;
  assign out_h      = out_valid ? dh : '0;
  assign out_w      = out_valid ? dw : '0;
  assign drain_done = done_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_output_accumulation_buffer.sv
// Bench for output_accumulation_buffer: random and directed writes
// checked against an array model of the output map.
module tb_output_accumulation_buffer;

  localparam int DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_en = 1'b0;
  logic [1:0]  in_ch = '0;
  logic [1:0]  in_h = '0;
  logic [1:0]  in_w = '0;
  logic [31:0] in_val = '0;
  logic        in_ready;
  logic        start_drain = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic [1:0]  out_h;
  logic [1:0]  out_w;
  logic        drain_done;
  logic [15:0] drop_count;

  int          errors = 0;
  int          checks = 0;
  int          drops = 0;
  logic [31:0] model [DEPTH];

  output_accumulation_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .in_en       (in_en),
    .in_ch       (in_ch),
    .in_h        (in_h),
    .in_w        (in_w),
    .in_val      (in_val),
    .in_ready    (in_ready),
    .start_drain (start_drain),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_h       (out_h),
    .out_w       (out_w),
    .drain_done  (drain_done),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input bit chk_lat, input bit poke);
    int n;
    @(negedge clock);
    reset = 1'b1;
    in_en = 1'b0;
    start_drain = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(in_ready), 0);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_done", 64'(drain_done), 0);
    check("rst_drops", 64'(drop_count), 0);
    check("rst_out", {out_data, out_ch, out_h, out_w}, 0);
    reset = 1'b0;
    drops = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    n = 0;
    while (!in_ready && n < 200) begin
      in_en = poke && (n == 10);
      if (poke && n == 10) drops++;
      @(posedge clock);
      #1;
      n++;
    end
    in_en = 1'b0;
    if (chk_lat) check("clr_latency", 64'(n), 64'(DEPTH));
    else check("clr_done", 64'(in_ready), 1);
    @(negedge clock);
  endtask

  task automatic wr(input int ch, input int h, input int w,
                    input logic [31:0] v);
    in_en  = 1'b1;
    in_ch  = 2'(ch);
    in_h   = 2'(h);
    in_w   = 2'(w);
    in_val = v;
    model[ch * 16 + h * 4 + w] = model[ch * 16 + h * 4 + w] + v;
    @(negedge clock);
  endtask

  task automatic fill_addr();
    for (int a = 0; a < DEPTH; a++) wr(a / 16, (a / 4) % 4, a % 4, 32'(a));
    in_en = 1'b0;
  endtask

  task automatic rand_round(input int n);
    int a;
    int prev;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_en = 1'b0;
        @(negedge clock);
      end else begin
        if ($urandom_range(0, 2) == 0) a = prev;
        else a = int'($urandom_range(0, DEPTH - 1));
        wr(a / 16, (a / 4) % 4, a % 4, $urandom());
        prev = a;
      end
    end
    in_en = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1,0,..., 2: random ready
  task automatic drain(input int mode, input int abort_at, input string tag);
    int          idx;
    int          cyc;
    bit          held;
    bit          poked;
    bit          done;
    logic [38:0] held_v;
    idx = 0;
    cyc = 0;
    held = 0;
    poked = 0;
    done = 0;
    held_v = '0;
    start_drain = 1'b1;
    @(negedge clock);
    start_drain = 1'b0;
    while (!done && cyc < 1000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        check("abort_valid", 64'(out_valid), 0);
        return;
      end
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (cyc % 2 == 0);
      else out_ready = 1'($urandom_range(0, 1));
      in_en = 1'b0;
      if (mode == 1 && idx == 5 && !poked) begin
        in_en = 1'b1;
        in_ch = 2'd1;
        in_h = 2'd1;
        in_w = 2'd1;
        in_val = 32'd99;
        drops++;
        poked = 1;
      end
      if (held)
        check({tag, "_hold"}, {out_valid, out_data, out_ch, out_h, out_w},
              {held_v});
      held = 0;
      if (out_valid) begin
        if (out_ready) begin
          check(tag, {out_data, out_ch, out_h, out_w},
                {model[idx], 2'(idx / 16), 2'((idx / 4) % 4), 2'(idx % 4)});
          model[idx] = '0;
          idx++;
        end else begin
          held = 1;
          held_v = {out_valid, out_data, out_ch, out_h, out_w};
        end
      end
      @(negedge clock);
      cyc++;
      if (idx == DEPTH) begin
        check({tag, "_done"}, {62'd0, drain_done, out_valid}, 64'b10);
        done = 1;
      end
    end
    in_en = 1'b0;
    out_ready = 1'b0;
    check({tag, "_count"}, 64'(idx), 64'(DEPTH));
    @(negedge clock);
    check({tag, "_done_once"}, 64'(drain_done), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    do_reset(1, 1);
    check("drop_clear", 64'(drop_count), 64'(drops));
    drain(0, -1, "zero");

    wr(1, 2, 3, 32'd5);
    in_en = 1'b0;
    drain(0, -1, "single");

    wr(0, 0, 0, 32'd7);
    wr(0, 0, 0, -32'sd2);
    wr(0, 0, 0, 32'd10);
    in_en = 1'b0;
    check("fwd_model", 64'(model[0]), 15);
    drain(2, -1, "fwd");

    fill_addr();
    drain(1, -1, "toggle");
    check("drop_drain", 64'(drop_count), 64'(drops));
    drain(0, -1, "second");

    rand_round(200);
    drain(2, -1, "rand_a");
    rand_round(300);
    drain(2, -1, "rand_b");

    fill_addr();
    drain(0, 20, "abort");
    do_reset(1, 0);
    drain(0, -1, "post_abort");
    check("drop_final", 64'(drop_count), 64'(drops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
